regw_arbiter: RTL and testbench
===============================

# regw_arbiter

Arbiter for the single architectural register-file write port. It shares the port between the in-order writeback stage and long-latency units (divider, uncached-load return) that finish out of pipeline order. Long-latency results wait in a small FIFO. Writeback normally has priority, and an anti-starvation counter stalls writeback so queued results drain. Sits between the writeback stage and the regfile; drives writeback's `next_rdy_in`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: long-latency result queue entries; power of two, ≥2.
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations before the FIFO head is forced through; 1..15.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `wb_we`  in  1  — writeback requests a regfile write.
- `wb_idx`  in  `reg_idx_t` (5)  — writeback destination.
- `wb_data`  in  32  — writeback data.
- `wb_rdy`  out  1  — to writeback `next_rdy_in`; 0 holds the writeback stage.
- `lu_valid`  in  1  — long-latency result valid.
- `lu_idx`  in  `reg_idx_t` (5)  — long-latency destination.
- `lu_data`  in  32  — long-latency data.
- `lu_rdy`  out  1  — FIFO can accept.
- `rf_we`  out  1  — regfile write enable.
- `rf_idx`  out  `reg_idx_t` (5)  — regfile write index.
- `rf_data`  out  32  — regfile write data.
- `busy`  out  1  — FIFO non-empty.

## Operation
- Enqueue on `lu_valid & lu_rdy`. `lu_rdy = ~full`. There is no same-cycle enqueue/dequeue bypass when full.
- `lu_idx == 0`: the result is accepted (handshake completes) but not stored.
- `fifo_grant = ~empty & (~wb_we | starve_cnt == STARVE_LIMIT)`.
- When `fifo_grant` is 1: `rf_*` = FIFO head, `rf_we = 1`, head dequeued.
- Otherwise: `rf_we = wb_we & (wb_idx != 0)`, `rf_idx = wb_idx`, `rf_data = wb_data`.
- `wb_rdy = ~(fifo_grant & wb_we)`. Non-writing writeback instructions are never stalled.
- A stalled writeback holds its request unchanged. That request is written in the first cycle without `fifo_grant`.
- `starve_cnt`:
  - Cleared when the FIFO is empty or on dequeue.
  - Otherwise incremented when writeback wins while the FIFO is non-empty.
  - Saturates at `STARVE_LIMIT`.
- Write-after-write ordering between the two sources is guaranteed by the issue scoreboard. This block does not check it.

## Timing
- `rf_*`, `wb_rdy` and `lu_rdy` are combinational from inputs and registered state. No port-to-port combinational path runs from `lu_*` to `rf_*`.
- Latency from enqueue to regfile write is ≥1 cycle: 1 cycle when `wb_we` is low, otherwise at most `STARVE_LIMIT`+1 cycles for the FIFO head.
- Reset state: FIFO empty, `starve_cnt = 0`, perf counters 0.
- Outputs after reset: `busy = 0`, `lu_rdy = 1`, `wb_rdy = 1`, `rf_we = wb_we & (wb_idx != 0)`.
- Reset asserted mid-operation discards all queued results. No `rf_we` is issued from the FIFO afterwards.
- Full FIFO with `lu_valid`: `lu_rdy = 0`. The producer holds the request until `lu_rdy` returns.
- Pointers are `$clog2(FIFO_DEPTH)`+1 bits. Full/empty is decided by the MSB-differs compare, and wrap-around is modulo `FIFO_DEPTH`.

## Configuration
- `REGW_ARB_PERF_EN` defined: adds outputs `perf_conflict_cnt` (32) and `perf_stall_cnt` (32).
  - `perf_conflict_cnt` counts cycles with `wb_we & ~empty`.
  - `perf_stall_cnt` counts cycles with `wb_rdy == 0`.
  - Both wrap at 2^32 and clear on `rst`.
- Not defined: these ports and counters are absent.

## Structure
- Shared package (`cpu_defs`): `regw_req_t` struct {`reg_idx_t idx; u32_t data`}, constant `REG_ZERO = 5'd0`.
- Sub-module `regw_fifo`: parameterised synchronous FIFO of `regw_req_t` with push/pop/full/empty. The arbiter contains the grant logic and counters.

## Test plan
- Idle writeback, `lu` writes r5 = 0x0000_1234 → next cycle `rf_we = 1`, `rf_idx = 5`, `rf_data = 0x1234`; `busy` falls the following cycle.
- FIFO holds r7, `wb_we` held with r3, `STARVE_LIMIT = 4` → writeback wins 4 cycles. Cycle 5: r7 is written and `wb_rdy = 0`. Cycle 6: r3 is written and `wb_rdy = 1`.
- `FIFO_DEPTH = 2`, `wb_we` held, three back-to-back `lu` results → third sees `lu_rdy = 0` until the first forced dequeue, then is accepted.
- `lu` to r0 → `lu_rdy = 1`, `busy` stays 0, no `rf_we`. `wb_we` to r0 → `rf_we = 0`, `wb_rdy = 1`.
- FIFO full, `rst` pulse for one cycle → `busy = 0`, `lu_rdy = 1`, no FIFO-sourced `rf_we` thereafter.
- With `REGW_ARB_PERF_EN`, scenario 2 → `perf_conflict_cnt = 5`, `perf_stall_cnt = 1`.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU register-write types used by the regfile write-port arbiter and its FIFO.
package cpu_defs;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] u32_t;

    typedef struct packed {
        reg_idx_t idx;
        u32_t     data;
    } regw_req_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regw_fifo.sv
// Synchronous FIFO of register-write requests; pointers carry an extra wrap bit for full/empty.
module regw_fifo
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  regw_req_t push_req,
    input  logic      pop,
    output regw_req_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    regw_req_t   mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_req;
        end
    end

endmodule

// File: rtl/regw_arbiter.sv
// Regfile write-port arbiter between writeback and queued long-latency results.
// Optional perf counters are enabled with `define REGW_ARB_PERF_EN.
module regw_arbiter
    import cpu_defs::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  reg_idx_t    wb_idx,
    input  u32_t        wb_data,
    output logic        wb_rdy,
    input  logic        lu_valid,
    input  reg_idx_t    lu_idx,
    input  u32_t        lu_data,
    output logic        lu_rdy,
    output logic        rf_we,
    output reg_idx_t    rf_idx,
    output u32_t        rf_data,
    output logic        busy
`ifdef REGW_ARB_PERF_EN
    ,
    output logic [31:0] perf_conflict_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic      full, empty, push, fifo_grant;
    regw_req_t head;
    logic [3:0] starve_cnt_q;

    // Writes to r0 complete the handshake but are dropped before the FIFO.
    assign lu_rdy     = ~full;
    assign push       = lu_valid & ~full & (lu_idx != REG_ZERO);
    assign fifo_grant = ~empty & (~wb_we | (starve_cnt_q == LIMIT));
    assign wb_rdy     = ~(fifo_grant & wb_we);
    assign busy       = ~empty;

    regw_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req ('{idx: lu_idx, data: lu_data}),
        .pop      (fifo_grant),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        rf_we   = wb_we & (wb_idx != REG_ZERO);
        rf_idx  = wb_idx;
        rf_data = wb_data;
        if (fifo_grant) begin
            rf_we   = 1'b1;
            rf_idx  = head.idx;
            rf_data = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (empty || fifo_grant) begin
            starve_cnt_q <= '0;
        end else if (wb_we && (starve_cnt_q != LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end

`ifdef REGW_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (wb_we && !empty) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (!wb_rdy) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regw_arbiter.sv
// Self-checking bench for regw_arbiter (FIFO_DEPTH = 2, STARVE_LIMIT = 4).
module tb_regw_arbiter;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        wb_rdy;
    logic        lu_valid;
    logic [4:0]  lu_idx;
    logic [31:0] lu_data;
    logic        lu_rdy;
    logic        rf_we;
    logic [4:0]  rf_idx;
    logic [31:0] rf_data;
    logic        busy;
`ifdef REGW_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    regw_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .wb_rdy   (wb_rdy),
        .lu_valid (lu_valid),
        .lu_idx   (lu_idx),
        .lu_data  (lu_data),
        .lu_rdy   (lu_rdy),
        .rf_we    (rf_we),
        .rf_idx   (rf_idx),
        .rf_data  (rf_data),
        .busy     (busy)
`ifdef REGW_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (lu_rdy !== 1'b1) begin n_err++; $display("FAIL reset_lu_rdy: got %b want 1", lu_rdy); end
        n_cmp++; if (wb_rdy !== 1'b1) begin n_err++; $display("FAIL reset_wb_rdy: got %b want 1", wb_rdy); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        tick();
        wb_we = 1'b1; wb_idx = 5'd9; wb_data = 32'h0000_0099;
        @(negedge clk);
        n_cmp++;
        if ({rf_we, rf_idx, rf_data} !== {1'b1, 5'd9, 32'h0000_0099}) begin
            n_err++; $display("FAIL reset_wb_pass: got we=%b idx=%0d data=%h want we=1 idx=9 data=00000099",
                              rf_we, rf_idx, rf_data);
        end
        tick();
        wb_we = 1'b0;
    endtask

    task automatic test_lu_idle();
        exp_t e;
        lu_valid = 1'b1; lu_idx = 5'd5; lu_data = 32'h0000_1234;
        @(negedge clk);
        n_cmp++; if (lu_rdy !== 1'b1) begin n_err++; $display("FAIL idle_lu_rdy: got %b want 1", lu_rdy); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL idle_no_bypass: got rf_we=%b want 0", rf_we); end
        if (lu_rdy) sb_q.push_back('{idx: 5'd5, data: 32'h0000_1234});
        tick();
        lu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL idle_busy: got %b want 1", busy); end
        n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL idle_rf_we: got %b want 1", rf_we); end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({rf_idx, rf_data} !== {e.idx, e.data}) begin
                n_err++; $display("FAIL idle_rf_data: got idx=%0d data=%h want idx=%0d data=%h",
                                  rf_idx, rf_data, e.idx, e.data);
            end
        end
        tick();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy_fall: got %b want 0", busy); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL idle_rf_we_after: got %b want 0", rf_we); end
        tick();
    endtask

    task automatic test_starve();
        exp_t e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lu_valid = 1'b1; lu_idx = 5'd7; lu_data = 32'h0000_00A7;
        @(negedge clk);
        n_cmp++; if (lu_rdy !== 1'b1) begin n_err++; $display("FAIL starve_lu_rdy: got %b want 1", lu_rdy); end
        if (lu_rdy) sb_q.push_back('{idx: 5'd7, data: 32'h0000_00A7});
        tick();
        lu_valid = 1'b0;
        wb_we = 1'b1; wb_idx = 5'd3; wb_data = 32'h0000_0033;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rf_we, rf_idx, rf_data, wb_rdy} !== {1'b1, 5'd3, 32'h0000_0033, 1'b1}) begin
                n_err++; $display("FAIL starve_wb_win%0d: got we=%b idx=%0d data=%h rdy=%b want we=1 idx=3 data=00000033 rdy=1",
                                  i, rf_we, rf_idx, rf_data, wb_rdy);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (wb_rdy !== 1'b0) begin n_err++; $display("FAIL starve_forced_wb_rdy: got %b want 0", wb_rdy); end
        n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL starve_forced_rf_we: got %b want 1", rf_we); end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({rf_idx, rf_data} !== {e.idx, e.data}) begin
                n_err++; $display("FAIL starve_forced_data: got idx=%0d data=%h want idx=%0d data=%h",
                                  rf_idx, rf_data, e.idx, e.data);
            end
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rf_we, rf_idx, rf_data, wb_rdy, busy} !== {1'b1, 5'd3, 32'h0000_0033, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL starve_wb_release: got we=%b idx=%0d data=%h rdy=%b busy=%b want 1/3/00000033/1/0",
                              rf_we, rf_idx, rf_data, wb_rdy, busy);
        end
`ifdef REGW_ARB_PERF_EN
        n_cmp++; if (perf_conflict_cnt !== 32'd5) begin n_err++; $display("FAIL perf_conflict: got %0d want 5", perf_conflict_cnt); end
        n_cmp++; if (perf_stall_cnt !== 32'd1) begin n_err++; $display("FAIL perf_stall: got %0d want 1", perf_stall_cnt); end
`endif
        tick();
        wb_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  bidx [3];
        logic [31:0] bdat [3];
        logic [6:0]  rdy_pat;
        exp_t        e;
        int          k;
        bidx[0] = 5'd10; bidx[1] = 5'd11; bidx[2] = 5'd12;
        bdat[0] = 32'hA0A0_0010; bdat[1] = 32'hB0B0_0011; bdat[2] = 32'hC0C0_0012;
        rdy_pat = 7'b1000011;
        k = 0;
        wb_we = 1'b1; wb_idx = 5'd4; wb_data = 32'h0000_0044;
        for (int c = 0; c < 7; c++) begin
            lu_valid = (k < 3);
            if (k < 3) begin
                lu_idx = bidx[k]; lu_data = bdat[k];
            end
            @(negedge clk);
            n_cmp++;
            if (lu_rdy !== rdy_pat[c]) begin
                n_err++; $display("FAIL b2b_lu_rdy_c%0d: got %b want %b", c, lu_rdy, rdy_pat[c]);
            end
            if (c == 5) begin
                n_cmp++;
                if ({rf_we, wb_rdy} !== 2'b10) begin
                    n_err++; $display("FAIL b2b_forced_c5: got we=%b rdy=%b want we=1 rdy=0", rf_we, wb_rdy);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    if ({rf_idx, rf_data} !== {e.idx, e.data}) begin
                        n_err++; $display("FAIL b2b_forced_data: got idx=%0d data=%h want idx=%0d data=%h",
                                          rf_idx, rf_data, e.idx, e.data);
                    end
                end
            end else begin
                n_cmp++;
                if ({rf_we, rf_idx, wb_rdy} !== {1'b1, 5'd4, 1'b1}) begin
                    n_err++; $display("FAIL b2b_wb_c%0d: got we=%b idx=%0d rdy=%b want we=1 idx=4 rdy=1",
                                      c, rf_we, rf_idx, wb_rdy);
                end
            end
            if (lu_valid && lu_rdy) begin
                sb_q.push_back('{idx: bidx[k], data: bdat[k]});
                k++;
            end
            tick();
        end
        lu_valid = 1'b0;
        wb_we = 1'b0;
        n_cmp++; if (k != 3) begin n_err++; $display("FAIL b2b_accepted: got %0d want 3", k); end
        for (int c = 7; c < 9; c++) begin
            @(negedge clk);
            n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL b2b_drain_we_c%0d: got %b want 1", c, rf_we); end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({rf_idx, rf_data} !== {e.idx, e.data}) begin
                    n_err++; $display("FAIL b2b_drain_data_c%0d: got idx=%0d data=%h want idx=%0d data=%h",
                                      c, rf_idx, rf_data, e.idx, e.data);
                end
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, rf_we} !== 2'b00) begin
            n_err++; $display("FAIL b2b_drained: got busy=%b we=%b want 0/0", busy, rf_we);
        end
        tick();
    endtask

    task automatic test_r0();
        lu_valid = 1'b1; lu_idx = 5'd0; lu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++; if (lu_rdy !== 1'b1) begin n_err++; $display("FAIL r0_lu_rdy: got %b want 1", lu_rdy); end
        tick();
        lu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL r0_busy: got %b want 0", busy); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_lu_rf_we: got %b want 0", rf_we); end
        tick();
        wb_we = 1'b1; wb_idx = 5'd0; wb_data = 32'h1111_2222;
        @(negedge clk);
        n_cmp++;
        if ({rf_we, wb_rdy} !== 2'b01) begin
            n_err++; $display("FAIL r0_wb: got we=%b rdy=%b want we=0 rdy=1", rf_we, wb_rdy);
        end
        tick();
        wb_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        wb_we = 1'b1; wb_idx = 5'd0; wb_data = 32'h0;
        lu_valid = 1'b1; lu_idx = 5'd20; lu_data = 32'h2020_2020;
        tick();
        lu_idx = 5'd21; lu_data = 32'h2121_2121;
        tick();
        lu_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({lu_rdy, busy, rf_we} !== 3'b010) begin
            n_err++; $display("FAIL rstmid_full: got rdy=%b busy=%b we=%b want 0/1/0", lu_rdy, busy, rf_we);
        end
        tick();
        rst = 1'b0;
        wb_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, lu_rdy, rf_we} !== 3'b010) begin
                n_err++; $display("FAIL rstmid_after_c%0d: got busy=%b rdy=%b we=%b want 0/1/0",
                                  c, busy, lu_rdy, rf_we);
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wb_we = 1'b0; wb_idx = '0; wb_data = '0;
        lu_valid = 1'b0; lu_idx = '0; lu_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_lu_idle();
        test_starve();
        test_back_to_back();
        test_r0();
        test_reset_mid();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
